// File: rtl/tx_hold_arbiter.sv
// tx_hold_arbiter: arbitrates between two requesters with a round-robin policy and owns the
// shared TX holding register.
//   clk, rst          : clock and synchronous active-high reset
//   req0/data0/ack0   : requester 0 handshake (ack0 is a one-cycle capture pulse)
//   req1/data1/ack1   : requester 1 handshake (ack1 is a one-cycle capture pulse)
//   q_out/out_valid   : holding register contents and valid flag for the transmitter
//   out_ready         : transmitter accepts q_out this cycle
//   grant_id          : requester that supplied the current q_out word
//   xfer_cnt          : wrapping count of completed out_valid & out_ready transfers
module tx_hold_arbiter #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack1,
    output logic [WIDTH-1:0] q_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             grant_id,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   q_out_q, q_out_d;
    logic               out_valid_q, out_valid_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               grant_id_q, grant_id_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;

    logic qreq0, qreq1, winner, xfer, load;

    always_comb begin
        // A request still high during its own ack cycle has already been served.
        qreq0  = req0 & ~ack0_q;
        qreq1  = req1 & ~ack1_q;
        winner = (qreq0 & qreq1) ? ~last_grant_q : qreq1;
        xfer   = (state_q == StHold) & out_ready;
        // Capture is possible from IDLE, or in HOLD on the same edge the current word leaves.
        load   = (qreq0 | qreq1) & ((state_q == StIdle) | out_ready);

        state_d      = state_q;
        q_out_d      = q_out_q;
        out_valid_d  = out_valid_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        xfer_cnt_d   = xfer_cnt_q;

        if (xfer) begin
            xfer_cnt_d  = xfer_cnt_q + 1'b1;
            state_d     = StIdle;
            out_valid_d = 1'b0;
        end

        if (load) begin
            q_out_d      = winner ? data1 : data0;
            grant_id_d   = winner;
            last_grant_d = winner;
            ack0_d       = ~winner;
            ack1_d       = winner;
            state_d      = StHold;
            out_valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            q_out_q      <= '0;
            out_valid_q  <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
            xfer_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            q_out_q      <= q_out_d;
            out_valid_q  <= out_valid_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            xfer_cnt_q   <= xfer_cnt_d;
        end
    end

    assign q_out     = q_out_q;
    assign out_valid = out_valid_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign grant_id  = grant_id_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_tx_hold_arbiter.sv
// Bench for tx_hold_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level reference model of the arbiter.
module tb_tx_hold_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, out_ready;
    logic [11:0] data0, data1;
    logic        ack0, ack1, out_valid, grant_id;
    logic [11:0] q_out;
    logic [7:0]  xfer_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit        m_valid, m_gid, m_last, m_ack0, m_ack1;
    bit [11:0] m_q;
    bit [7:0]  m_cnt;
    int        m_total;

    tx_hold_arbiter #(.WIDTH(12), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .data0     (data0),
        .ack0      (ack0),
        .req1      (req1),
        .data1     (data1),
        .ack1      (ack1),
        .q_out     (q_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock: model consumes the inputs as they stand at the edge, DUT likewise.
    task automatic tick();
        bit n_valid, n_gid, n_last, n_ack0, n_ack1, p0, p1, w;
        bit [11:0] n_q;
        bit [7:0]  n_cnt;
        int        n_total;
        n_valid = m_valid; n_gid = m_gid; n_last = m_last; n_q = m_q;
        n_cnt = m_cnt; n_total = m_total; n_ack0 = 0; n_ack1 = 0;
        if (rst) begin
            n_valid = 0; n_gid = 0; n_last = 1; n_q = 0; n_cnt = 0;
        end else begin
            p0 = req0 && !m_ack0;
            p1 = req1 && !m_ack1;
            if (m_valid && out_ready) begin
                n_cnt   = m_cnt + 8'd1;
                n_total = m_total + 1;
                n_valid = 0;
            end
            if ((p0 || p1) && (!m_valid || out_ready)) begin
                w       = (p0 && p1) ? !m_last : p1;
                n_q     = w ? data1 : data0;
                n_gid   = w;
                n_last  = w;
                n_ack0  = !w;
                n_ack1  = w;
                n_valid = 1;
            end
        end
        @(posedge clk);
        #1;
        m_valid = n_valid; m_gid = n_gid; m_last = n_last; m_q = n_q;
        m_cnt = n_cnt; m_total = n_total; m_ack0 = n_ack0; m_ack1 = n_ack1;
    endtask

    task automatic do_reset();
        rst = 1; req0 = 0; req1 = 0; out_ready = 0;
        tick();
        rst = 0;
        m_total = 0;
    endtask

    task automatic test_reset();
        data0 = 12'h0; data1 = 12'h0;
        rst = 1; req0 = 1; req1 = 1; out_ready = 1;
        tick();
        rst = 0; req0 = 0; req1 = 0; out_ready = 0;
        m_total = 0;
        checks++;
        if (out_valid !== 1'b0 || q_out !== 12'h0 || xfer_cnt !== 8'h0 || ack0 !== 1'b0 ||
            ack1 !== 1'b0 || grant_id !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b q=%h cnt=%0d ack=%b%b gid=%b, required all zero",
                     out_valid, q_out, xfer_cnt, ack0, ack1, grant_id);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: valid=%b ack=%b%b, required 0 00", out_valid, ack0, ack1);
        end
    endtask

    task automatic test_single();
        do_reset();
        req0 = 1; data0 = 12'hA5C;
        tick();
        checks++;
        if (q_out !== 12'hA5C || out_valid !== 1'b1 || ack0 !== 1'b1 || ack1 !== 1'b0 ||
            grant_id !== 1'b0) begin
            errors++;
            $display("FAIL single_load: q=%h valid=%b ack=%b%b gid=%b, required A5C 1 10 0",
                     q_out, out_valid, ack0, ack1, grant_id);
        end
        req0 = 0; out_ready = 1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || xfer_cnt !== 8'd1 || ack0 !== 1'b0) begin
            errors++;
            $display("FAIL single_xfer: valid=%b cnt=%0d ack0=%b, required 0 1 0",
                     out_valid, xfer_cnt, ack0);
        end
        out_ready = 0;
    endtask

    task automatic test_alternate();
        do_reset();
        req0 = 1; data0 = 12'h111; req1 = 1; data1 = 12'h222; out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (q_out !== ((i % 2 == 0) ? 12'h111 : 12'h222) || out_valid !== 1'b1 ||
                ack0 !== (i % 2 == 0) || ack1 !== (i % 2 == 1) || grant_id !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL alternate[%0d]: q=%h valid=%b ack=%b%b gid=%b, required %h 1 %b%b",
                         i, q_out, out_valid, ack0, ack1, grant_id,
                         (i % 2 == 0) ? 12'h111 : 12'h222, i % 2 == 0, i % 2 == 1);
            end
        end
        checks++;
        if (xfer_cnt !== 8'd7) begin
            errors++;
            $display("FAIL alternate_cnt: cnt=%0d, required 7", xfer_cnt);
        end
        req0 = 0; req1 = 0;
        tick();
        out_ready = 0;
    endtask

    task automatic test_stall();
        do_reset();
        req0 = 1; data0 = 12'h3C3; out_ready = 0;
        tick();
        req0 = 0; req1 = 1; data1 = 12'h5A5;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (q_out !== 12'h3C3 || out_valid !== 1'b1 || ack1 !== 1'b0 || xfer_cnt !== 8'd0) begin
                errors++;
                $display("FAIL stall[%0d]: q=%h valid=%b ack1=%b cnt=%0d, required 3C3 1 0 0",
                         i, q_out, out_valid, ack1, xfer_cnt);
            end
        end
        out_ready = 1;
        tick();
        checks++;
        if (q_out !== 12'h5A5 || out_valid !== 1'b1 || ack1 !== 1'b1 || grant_id !== 1'b1 ||
            xfer_cnt !== 8'd1) begin
            errors++;
            $display("FAIL stall_release: q=%h valid=%b ack1=%b gid=%b cnt=%0d, required 5A5 1 1 1 1",
                     q_out, out_valid, ack1, grant_id, xfer_cnt);
        end
        req1 = 0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || xfer_cnt !== 8'd2 || ack1 !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: valid=%b cnt=%0d ack1=%b, required 0 2 0",
                     out_valid, xfer_cnt, ack1);
        end
        out_ready = 0;
    endtask

    task automatic test_one_capture();
        do_reset();
        req0 = 1; data0 = 12'h0F0; out_ready = 1;
        tick();
        // req0 stays high through the ack cycle, then drops.
        tick();
        req0 = 0;
        checks++;
        if (out_valid !== 1'b0 || ack0 !== 1'b0 || xfer_cnt !== 8'd1) begin
            errors++;
            $display("FAIL one_capture: valid=%b ack0=%b cnt=%0d, required 0 0 1",
                     out_valid, ack0, xfer_cnt);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || xfer_cnt !== 8'd1) begin
            errors++;
            $display("FAIL one_capture_idle: valid=%b cnt=%0d, required 0 1", out_valid, xfer_cnt);
        end
        out_ready = 0;
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        req0 = 1; data0 = 12'hABC; out_ready = 1;
        tick(); tick(); tick();
        req0 = 0; out_ready = 0;
        checks++;
        if (out_valid !== 1'b1 || xfer_cnt !== 8'd1) begin
            errors++;
            $display("FAIL rst_hold_pre: valid=%b cnt=%0d, required 1 1", out_valid, xfer_cnt);
        end
        rst = 1; req1 = 1; data1 = 12'h777;
        tick();
        rst = 0; m_total = 0;
        checks++;
        if (out_valid !== 1'b0 || q_out !== 12'h0 || xfer_cnt !== 8'd0 || ack0 !== 1'b0 ||
            ack1 !== 1'b0) begin
            errors++;
            $display("FAIL rst_hold: valid=%b q=%h cnt=%0d ack=%b%b, required 0 000 0 00",
                     out_valid, q_out, xfer_cnt, ack0, ack1);
        end
        req0 = 1; data0 = 12'h123;
        tick();
        checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || grant_id !== 1'b0 || q_out !== 12'h123) begin
            errors++;
            $display("FAIL rst_contention: ack=%b%b gid=%b q=%h, required 10 0 123",
                     ack0, ack1, grant_id, q_out);
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_wrap();
        int guard;
        do_reset();
        req0 = 1; req1 = 1; data0 = 12'h001; data1 = 12'h002; out_ready = 1;
        guard = 0;
        while (m_total < 259 && guard < 1000) begin
            tick();
            guard++;
        end
        req0 = 0; req1 = 0; out_ready = 0;
        checks++;
        if (m_total != 259 || xfer_cnt !== 8'd3) begin
            errors++;
            $display("FAIL wrap: cnt=%0d after %0d transfers, required 3 after 259",
                     xfer_cnt, m_total);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            tick();
            checks++;
            if (out_valid !== m_valid || ack0 !== m_ack0 || ack1 !== m_ack1 ||
                xfer_cnt !== m_cnt || (m_valid && (q_out !== m_q || grant_id !== m_gid))) begin
                errors++;
                $display("FAIL random[%0d]: v=%b q=%h a=%b%b g=%b c=%0d, required v=%b q=%h a=%b%b g=%b c=%0d",
                         i, out_valid, q_out, ack0, ack1, grant_id, xfer_cnt,
                         m_valid, m_q, m_ack0, m_ack1, m_gid, m_cnt);
            end
            checks++;
            if (ack0 === 1'b1 && ack1 === 1'b1) begin
                errors++;
                $display("FAIL random_ack_overlap[%0d]: ack0=1 ack1=1, required not both", i);
            end
            // Requester agents: drop on ack, occasionally withdraw, otherwise raise new words.
            if (ack0) req0 = 0;
            else if (req0) begin
                if ($urandom_range(15) == 0) req0 = 0;
            end else if ($urandom_range(1) == 0) begin
                req0 = 1; data0 = 12'($urandom);
            end
            if (ack1) req1 = 0;
            else if (req1) begin
                if ($urandom_range(15) == 0) req1 = 0;
            end else if ($urandom_range(1) == 0) begin
                req1 = 1; data1 = 12'($urandom);
            end
            out_ready = ($urandom_range(3) != 0);
            rst = ($urandom_range(99) == 0);
        end
        rst = 0; req0 = 0; req1 = 0; out_ready = 0;
    endtask

    initial begin
        rst = 1; req0 = 0; req1 = 0; out_ready = 0; data0 = 0; data1 = 0;
        test_reset();
        test_single();
        test_alternate();
        test_stall();
        test_one_capture();
        test_reset_in_hold();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
